// File: rtl/rf_wb_queue.sv
// Write-back queue between the ALU / load paths and the register-file write port.
// Buffers writes in acceptance order, drains one per cycle, and forwards pending data to operand reads.
module rf_wb_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          alu_valid,
   input  logic [AW-1:0] alu_rd,
   input  logic [DW-1:0] alu_data,
   output logic          alu_ready,
   input  logic          mem_valid,
   input  logic [AW-1:0] mem_rd,
   input  logic [DW-1:0] mem_data,
   output logic          mem_ready,
   output logic          rf_wr,
   output logic [AW-1:0] rf_rd,
   output logic [DW-1:0] rf_wd,
   input  logic [AW-1:0] q_rs,
   input  logic [AW-1:0] q_rt,
   output logic          fwd1_hit,
   output logic [DW-1:0] fwd1_data,
   output logic          fwd2_hit,
   output logic [DW-1:0] fwd2_data
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [AW-1:0] ent_rd_q   [DEPTH];
   logic [AW-1:0] ent_rd_d   [DEPTH];
   logic [DW-1:0] ent_data_q [DEPTH];
   logic [DW-1:0] ent_data_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [CW-1:0] free;
   logic          mem_acc, alu_acc;
   logic          mem_push, alu_push;
   logic          pop;
   logic [PW-1:0] alu_slot;

   // Readiness looks only at the registered occupancy, so a pop in this
   // cycle never frees a slot for a push in the same cycle.
   always_comb begin
      free      = DEPTH_C - count_q;
      mem_ready = (free >= CW'(1));
      alu_ready = (free >= (mem_valid ? CW'(2) : CW'(1)));
   end

   always_comb begin
      mem_acc  = mem_valid & mem_ready;
      alu_acc  = alu_valid & alu_ready;
      mem_push = mem_acc & (mem_rd != '0);
      alu_push = alu_acc & (alu_rd != '0);
      pop      = (count_q != '0);
      alu_slot = wr_ptr_q + PW'(mem_push);
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_rd_d[i]   = ent_rd_q[i];
         ent_data_d[i] = ent_data_q[i];
      end
      // The load entry is older than an ALU entry accepted in the same cycle.
      if (mem_push) begin
         ent_rd_d[wr_ptr_q]   = mem_rd;
         ent_data_d[wr_ptr_q] = mem_data;
      end
      if (alu_push) begin
         ent_rd_d[alu_slot]   = alu_rd;
         ent_data_d[alu_slot] = alu_data;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(mem_push) + PW'(alu_push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry payload needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_rd_q[i]   <= ent_rd_d[i];
         ent_data_q[i] <= ent_data_d[i];
      end
   end

   always_comb begin
      rf_wr = (count_q != '0);
      rf_rd = ent_rd_q[rd_ptr_q];
      rf_wd = ent_data_q[rd_ptr_q];
   end

   // Walk oldest to youngest so a later match overrides an earlier one.
   logic [PW-1:0] scan_idx;
   always_comb begin
      fwd1_hit  = 1'b0;
      fwd1_data = '0;
      fwd2_hit  = 1'b0;
      fwd2_data = '0;
      scan_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = rd_ptr_q + PW'(i);
         if (CW'(i) < count_q) begin
            if ((q_rs != '0) && (ent_rd_q[scan_idx] == q_rs)) begin
               fwd1_hit  = 1'b1;
               fwd1_data = ent_data_q[scan_idx];
            end
            if ((q_rt != '0) && (ent_rd_q[scan_idx] == q_rt)) begin
               fwd2_hit  = 1'b1;
               fwd2_data = ent_data_q[scan_idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed bench for rf_wb_queue: single write, rd==0 drop, dual accept,
// saturation ordering, youngest-match forwarding and asynchronous reset.
module tb_rf_wb_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          alu_valid = 1'b0;
   logic [AW-1:0] alu_rd = '0;
   logic [DW-1:0] alu_data = '0;
   logic          alu_ready;
   logic          mem_valid = 1'b0;
   logic [AW-1:0] mem_rd = '0;
   logic [DW-1:0] mem_data = '0;
   logic          mem_ready;
   logic          rf_wr;
   logic [AW-1:0] rf_rd;
   logic [DW-1:0] rf_wd;
   logic [AW-1:0] q_rs = '0;
   logic [AW-1:0] q_rt = '0;
   logic          fwd1_hit;
   logic [DW-1:0] fwd1_data;
   logic          fwd2_hit;
   logic [DW-1:0] fwd2_data;

   int checks = 0;
   int errors = 0;
   logic [AW+DW-1:0] exp_q[$];

   rf_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_wd(rf_wd),
      .q_rs(q_rs), .q_rt(q_rt),
      .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
      .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      alu_rd = '0;
      mem_rd = '0;
      alu_data = '0;
      mem_data = '0;
   endtask

   task automatic test_reset;
      idle_inputs();
      #12;
      checks++;
      if (rf_wr !== 1'b0) begin errors++; $display("FAIL reset_rf_wr: got %b expected 0", rf_wr); end
      checks++;
      if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0) begin
         errors++; $display("FAIL reset_fwd_hit: got %b%b expected 00", fwd1_hit, fwd2_hit);
      end
      checks++;
      if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got mem=%b alu=%b expected 1 1", mem_ready, alu_ready);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_write;
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
      #1;
      checks++;
      if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready: got %b expected 1", alu_ready); end
      tick();
      idle_inputs();
      q_rs = 5'd5;
      #1;
      checks++;
      if (rf_wr !== 1'b1 || rf_rd !== 5'd5 || rf_wd !== 32'h1234) begin
         errors++; $display("FAIL single_write: got wr=%b rd=%0d wd=%h expected 1 5 00001234", rf_wr, rf_rd, rf_wd);
      end
      checks++;
      if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h1234) begin
         errors++; $display("FAIL single_fwd_head: got hit=%b data=%h expected 1 00001234", fwd1_hit, fwd1_data);
      end
      tick();
      checks++;
      if (rf_wr !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", rf_wr); end
      checks++;
      if (fwd1_hit !== 1'b0 || fwd1_data !== 32'h0) begin
         errors++; $display("FAIL single_fwd_clear: got hit=%b data=%h expected 0 00000000", fwd1_hit, fwd1_data);
      end
   endtask

   task automatic test_rd_zero;
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
      q_rs = 5'd0;
      #1;
      checks++;
      if (alu_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready: got %b expected 1", alu_ready); end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (rf_wr !== 1'b0) begin errors++; $display("FAIL rd0_no_write: got %b expected 0", rf_wr); end
      checks++;
      if (fwd1_hit !== 1'b0) begin errors++; $display("FAIL rd0_no_fwd: got %b expected 0", fwd1_hit); end
      tick();
      checks++;
      if (rf_wr !== 1'b0) begin errors++; $display("FAIL rd0_still_idle: got %b expected 0", rf_wr); end
   endtask

   task automatic test_dual_accept;
      mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hAA;
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hBB;
      #1;
      checks++;
      if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
         errors++; $display("FAIL dual_ready: got mem=%b alu=%b expected 1 1", mem_ready, alu_ready);
      end
      tick();
      idle_inputs();
      checks++;
      if (rf_wr !== 1'b1 || rf_rd !== 5'd3 || rf_wd !== 32'hAA) begin
         errors++; $display("FAIL dual_first: got wr=%b rd=%0d wd=%h expected 1 3 000000aa", rf_wr, rf_rd, rf_wd);
      end
      tick();
      checks++;
      if (rf_wr !== 1'b1 || rf_rd !== 5'd4 || rf_wd !== 32'hBB) begin
         errors++; $display("FAIL dual_second: got wr=%b rd=%0d wd=%h expected 1 4 000000bb", rf_wr, rf_rd, rf_wd);
      end
      tick();
      checks++;
      if (rf_wr !== 1'b0) begin errors++; $display("FAIL dual_drained: got %b expected 0", rf_wr); end
   endtask

   task automatic test_back_to_back;
      int mem_seq = 0;
      int alu_seq = 0;
      int free;
      int guard;
      logic e_mem, e_alu;
      exp_q.delete();
      for (int cyc = 0; cyc < 16; cyc++) begin
         checks++;
         if (exp_q.size() != 0) begin
            if (rf_wr !== 1'b1 || {rf_rd, rf_wd} !== exp_q[0]) begin
               errors++; $display("FAIL b2b_write cyc %0d: got wr=%b %h expected 1 %h", cyc, rf_wr, {rf_rd, rf_wd}, exp_q[0]);
            end
         end else if (rf_wr !== 1'b0) begin
            errors++; $display("FAIL b2b_idle cyc %0d: got wr=%b expected 0", cyc, rf_wr);
         end
         mem_valid = (cyc % 4 != 3);
         mem_rd    = AW'(1 + mem_seq % 15);
         mem_data  = 32'h100 + DW'(mem_seq);
         alu_valid = 1'b1;
         alu_rd    = AW'(16 + alu_seq % 15);
         alu_data  = 32'h200 + DW'(alu_seq);
         #1;
         free  = DEPTH - exp_q.size();
         e_mem = (free >= 1);
         e_alu = (free >= (mem_valid ? 2 : 1));
         checks++;
         if (mem_ready !== e_mem || alu_ready !== e_alu) begin
            errors++; $display("FAIL b2b_ready cyc %0d: got mem=%b alu=%b expected %b %b", cyc, mem_ready, alu_ready, e_mem, e_alu);
         end
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         if (mem_valid && e_mem) begin exp_q.push_back({mem_rd, mem_data}); mem_seq++; end
         if (e_alu) begin exp_q.push_back({alu_rd, alu_data}); alu_seq++; end
         tick();
      end
      idle_inputs();
      guard = 0;
      while (exp_q.size() != 0 && guard < 10) begin
         checks++;
         if (rf_wr !== 1'b1 || {rf_rd, rf_wd} !== exp_q[0]) begin
            errors++; $display("FAIL b2b_drain: got wr=%b %h expected 1 %h", rf_wr, {rf_rd, rf_wd}, exp_q[0]);
         end
         void'(exp_q.pop_front());
         guard++;
         tick();
      end
      checks++;
      if (exp_q.size() != 0 || rf_wr !== 1'b0) begin
         errors++; $display("FAIL b2b_end: got wr=%b left=%0d expected 0 0", rf_wr, exp_q.size());
      end
   endtask

   task automatic test_forward_youngest;
      mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h2;
      q_rs = 5'd7; q_rt = 5'd9;
      #1;
      checks++;
      if (fwd1_hit !== 1'b0) begin errors++; $display("FAIL fwd_unaccepted: got %b expected 0", fwd1_hit); end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h2) begin
         errors++; $display("FAIL fwd_both_pending: got hit=%b data=%h expected 1 00000002", fwd1_hit, fwd1_data);
      end
      checks++;
      if (fwd2_hit !== 1'b0 || fwd2_data !== 32'h0) begin
         errors++; $display("FAIL fwd2_miss: got hit=%b data=%h expected 0 00000000", fwd2_hit, fwd2_data);
      end
      q_rt = 5'd7;
      #1;
      checks++;
      if (fwd2_hit !== 1'b1 || fwd2_data !== 32'h2) begin
         errors++; $display("FAIL fwd2_hit: got hit=%b data=%h expected 1 00000002", fwd2_hit, fwd2_data);
      end
      tick();
      checks++;
      if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h2 || rf_wd !== 32'h2) begin
         errors++; $display("FAIL fwd_after_drain: got hit=%b data=%h wd=%h expected 1 00000002 00000002", fwd1_hit, fwd1_data, rf_wd);
      end
      tick();
      checks++;
      if (fwd1_hit !== 1'b0 || fwd1_data !== 32'h0 || fwd2_hit !== 1'b0) begin
         errors++; $display("FAIL fwd_empty: got hit=%b data=%h hit2=%b expected 0 00000000 0", fwd1_hit, fwd1_data, fwd2_hit);
      end
   endtask

   task automatic test_async_reset;
      mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'h11;
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
      tick();
      mem_rd = 5'd3; mem_data = 32'h33;
      alu_rd = 5'd4; alu_data = 32'h44;
      tick();
      idle_inputs();
      q_rs = 5'd3;
      #1;
      checks++;
      if (rf_wr !== 1'b1 || rf_rd !== 5'd2 || fwd1_hit !== 1'b1) begin
         errors++; $display("FAIL rst_prefill: got wr=%b rd=%0d hit=%b expected 1 2 1", rf_wr, rf_rd, fwd1_hit);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (rf_wr !== 1'b0 || fwd1_hit !== 1'b0) begin
         errors++; $display("FAIL rst_async: got wr=%b hit=%b expected 0 0", rf_wr, fwd1_hit);
      end
      checks++;
      if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
         errors++; $display("FAIL rst_ready: got mem=%b alu=%b expected 1 1", mem_ready, alu_ready);
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (rf_wr !== 1'b0 || fwd1_hit !== 1'b0) begin
            errors++; $display("FAIL rst_no_stale %0d: got wr=%b hit=%b expected 0 0", i, rf_wr, fwd1_hit);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_rd_zero();
      test_dual_accept();
      test_back_to_back();
      test_forward_youngest();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
